// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with private HI/LO registers and start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; divide stays iterative.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0] r_hi, r_lo, r_opb, r_acc_hi, r_acc_lo, r_a_orig;

  logic             w_accept, w_mt, w_sa, w_sb;
  logic [WIDTH-1:0] w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0]   w_mul_sum, w_div_sh, w_div_diff;
  logic [PW-1:0]    w_prod, w_prod_fix;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // op[2]=0: mul/div, op[1]: divide, op[0]: signed (or LO select for MTHI/MTLO)
  assign w_accept = start & (r_state == S_IDLE) & ~op[2];
  assign w_mt     = start & (r_state == S_IDLE) & (op[2:1] == 2'b10);

  always_comb begin
    w_sa       = op[0] & src_a[WIDTH-1];
    w_sb       = op[0] & src_b[WIDTH-1];
    w_ma       = w_sa ? (~src_a + WIDTH'(1)) : src_a;
    w_mb       = w_sb ? (~src_b + WIDTH'(1)) : src_b;
    w_mul_sum  = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opb : {WIDTH{1'b0}})};
    w_div_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, r_opb};
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
    w_q        = r_neg_q ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
    w_r        = r_neg_r ? (~r_acc_hi + WIDTH'(1)) : r_acc_hi;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] w_fast;
  assign w_fast = PW'(w_ma) * PW'(w_mb);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
          w_state_nxt = op[1] ? S_RUN : S_FINISH;
`else
          w_state_nxt = S_RUN;
`endif
        end
      end
      S_RUN:    if (r_cnt == '0) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Working registers, HI/LO and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_a_orig <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mt) begin
            if (op[0]) r_lo <= src_a;
            else       r_hi <= src_a;
          end
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_opb    <= w_mb;
            r_acc_hi <= '0;
            r_acc_lo <= w_ma;
            r_cnt    <= CW'(WIDTH - 1);
            r_is_div <= op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= op[1] & (src_b == '0);
            r_a_orig <= src_a;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              r_acc_hi <= w_fast[PW-1:WIDTH];
              r_acc_lo <= w_fast[WIDTH-1:0];
            end
`endif
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            // Restoring step: keep the difference only when it did not borrow
            if (!w_div_diff[WIDTH]) begin
              r_acc_hi <= w_div_diff[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_acc_hi <= w_div_sh[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc_hi <= w_mul_sum[WIDTH:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_dz) begin
              r_hi <= r_a_orig;
              r_lo <= '1;
            end else begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
          end else begin
            r_hi <= w_prod_fix[PW-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised multi-cycle multiply/divide unit with its own HI/LO register pair, sitting beside the combinational ALU in the execute stage. It supports signed and unsigned multiply and divide, plus MTHI/MTLO writes. A start/busy/done handshake lets the pipeline stall on HI/LO reads while an operation is in flight. The iterative datapath replaces the single-cycle `*`, `/` and `%` operators, removing them from the critical path.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled on a rising edge only while busy=0
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110 and 111 are no-ops
- src_a  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data
- src_b  in  WIDTH  multiplier or divisor
- busy  out  1  operation in flight; the pipeline must stall any HI/LO read while busy=1
- done  out  1  single-cycle pulse when HI/LO have just been updated by a mul/div
- hi  out  WIDTH  HI register (product upper half, or remainder)
- lo  out  WIDTH  LO register (product lower half, or quotient)

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1, op is a mul/div:
  - Latch the operands, and latch the signs for MULT/DIV.
  - Convert signed operands to magnitudes.
  - Load the iteration counter with WIDTH−1 and go to RUN.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) ← src_a at that edge.
  - Stay in IDLE; busy and done remain 0.
- IDLE, start=1, op=110/111: no effect.
- RUN, multiply: one shift-add step per cycle on the {HI,LO} accumulator.
- RUN, divide: one restoring shift-subtract step per cycle.
- RUN exit: when the counter reaches 0, go to FINISH.
- FINISH:
  - Apply the sign fix-up.
  - Write hi/lo, pulse done, return to IDLE.
- Result rules:
  - MULTU: {hi,lo} = a×b, full 2·WIDTH-bit unsigned product.
  - MULT: two's-complement 2·WIDTH-bit product.
  - DIVU: lo = a/b, hi = a%b.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV with a = most-negative and b = −1: lo = most-negative, hi = 0.
- Divide by zero (DIVU or DIV): hi = src_a unchanged, lo = all ones. Full latency still applies, and no exception is raised.
- Arithmetic: all internal accumulators are WIDTH+1 bits wide (divide) or 2·WIDTH bits wide (multiply). No result is truncated other than as stated above.
- hi/lo are not modified during RUN. The intermediate state lives in separate working registers.
- start while busy=1: ignored, with no queuing.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-operation aborts it. hi/lo are cleared, and no done pulse is produced.
- For a mul/div, start is sampled at edge E0:
  - busy=1 from after E0 through edge E(WIDTH+1).
  - hi/lo are updated at E(WIDTH+1).
  - done=1 for exactly the cycle following E(WIDTH+1), with busy=0 in that same cycle.
  - Latency is therefore WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: a new start may be issued in the done cycle and is accepted at the next edge. Minimum issue interval is WIDTH+2 cycles.
- MTHI/MTLO: zero-latency register write at E0; the new value is visible on hi/lo in the next cycle.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the product combinationally at E0.
  - The FSM skips RUN: IDLE → FINISH.
  - hi/lo are written at E1, done pulses in the following cycle, and busy is high for one cycle.
  - Divide behaviour is unchanged.
- MULDIV_FAST_MUL_EN undefined: multiply is iterative with WIDTH+1 latency, as described above.

## Test plan
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done is high for exactly one cycle. With MULDIV_FAST_MUL_EN, the same result arrives after 1 cycle.
- MULT with a=−3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV with a=−7, b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Separately, DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU with a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF after 33 cycles. A start pulsed with op=MULTU mid-operation is ignored, and hi/lo do not change during busy.
- MTHI 0xA5A5A5A5 followed next cycle by MTLO 0x5A5A5A5A -> hi/lo hold those values and done is never asserted. Then start a DIVU, assert reset at cycle 10 -> hi=lo=0, busy=0, and no done pulse.
- Back-to-back: MULTU 3×5 with a DIVU 100/7 issued in the done cycle -> first {hi,lo}={0,15}; second hi=2, lo=14, with done asserted 34 cycles after the first done.
